// File: rtl/vrf_pkg.sv
// Shared VRF definitions: move-engine state encoding and default VRF geometry
// (the arbiter uses the same geometry constants).
package vrf_pkg;

    localparam int DEFAULT_VRF_ADDR_WIDTH = 10;
    localparam int DEFAULT_VRF_DATA_WIDTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } vrf_move_state_e;

endpackage

// File: rtl/vrf_move_perf_cnt.sv
// Saturating stall/beat counter pair for the VRF move engine.
// Only instantiated when VRF_MOVE_PERF_CNT_EN is defined.
module vrf_move_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        stall_inc_i,
    input  logic        beat_inc_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] beat_cnt_o
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    // Clearing has priority; it only coincides with command acceptance,
    // when no request is outstanding anyway.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (clr_i) begin
            stall_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
            if (beat_inc_i && (beat_cnt_q != '1))   beat_cnt_d  = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: rtl/vrf_move_engine.sv
// Router-side VRF move engine: reads each source word through the arbiter and writes it
// to the destination, one beat at a time. Optional counters under VRF_MOVE_PERF_CNT_EN.
module vrf_move_engine
    import vrf_pkg::*;
#(
    parameter int VRF_ADDR_WIDTH = DEFAULT_VRF_ADDR_WIDTH,
    parameter int VRF_DATA_WIDTH = DEFAULT_VRF_DATA_WIDTH,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_src_addr_i,
    input  logic [VRF_ADDR_WIDTH-1:0] cmd_dst_addr_i,
    input  logic [LEN_WIDTH-1:0]      cmd_len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [VRF_ADDR_WIDTH-1:0] src_addr,
    input  logic [VRF_DATA_WIDTH-1:0] data_arbiter_send,
    output logic                      read_req,
    input  logic                      read_gnt,
    output logic [VRF_ADDR_WIDTH-1:0] dst_addr,
    output logic [VRF_DATA_WIDTH-1:0] data_arbiter_recv,
    output logic                      write_req,
    input  logic                      write_gnt
`ifdef VRF_MOVE_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               beat_cnt_o
`endif
);

    // Handshake: a request is held with stable address/data until its grant is
    // sampled high on a clock edge; the request drops on the following cycle.
    vrf_move_state_e state_q, state_d;
    logic [VRF_ADDR_WIDTH-1:0] src_q, src_d;
    logic [VRF_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [VRF_DATA_WIDTH-1:0] data_q, data_d;
    logic read_req_q, read_req_d;
    logic write_req_q, write_req_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic cmd_ready_q, cmd_ready_d;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        data_d      = data_q;
        read_req_d  = read_req_q;
        write_req_d = write_req_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cmd_ready_d = cmd_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    src_d       = cmd_src_addr_i;
                    dst_d       = cmd_dst_addr_i;
                    len_d       = cmd_len_i;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = (cmd_len_i == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                // First cycle in the state raises the request; nothing is issued on a grant cycle.
                if (!read_req_q) begin
                    read_req_d = 1'b1;
                end else if (read_gnt) begin
                    data_d     = data_arbiter_send;
                    read_req_d = 1'b0;
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                if (!write_req_q) begin
                    write_req_d = 1'b1;
                end else if (write_gnt) begin
                    write_req_d = 1'b0;
                    src_d       = src_q + VRF_ADDR_WIDTH'(1);
                    dst_d       = dst_q + VRF_ADDR_WIDTH'(1);
                    len_d       = len_q - LEN_WIDTH'(1);
                    state_d     = (len_q == LEN_WIDTH'(1)) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            read_req_q  <= 1'b0;
            write_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            data_q      <= data_d;
            read_req_q  <= read_req_d;
            write_req_q <= write_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready_o       = cmd_ready_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign src_addr          = src_q;
    assign dst_addr          = dst_q;
    assign data_arbiter_recv = data_q;
    assign read_req          = read_req_q;
    assign write_req         = write_req_q;

`ifdef VRF_MOVE_PERF_CNT_EN
    logic cmd_accept;
    logic stall_inc;
    logic beat_inc;

    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid_i;
    assign stall_inc  = (read_req_q && !read_gnt) || (write_req_q && !write_gnt);
    assign beat_inc   = write_req_q && write_gnt;

    vrf_move_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (cmd_accept),
        .stall_inc_i (stall_inc),
        .beat_inc_i  (beat_inc),
        .stall_cnt_o (stall_cnt_o),
        .beat_cnt_o  (beat_cnt_o)
    );
`endif

endmodule
